// File: rtl/pid_pkg.sv
// Shared widths and helpers for the PID controller datapath.
// The derived widths describe the default configuration; modules recompute them from their own parameters.
package pid_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_GAIN_W = 8;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_ACC_W  = 24;

  localparam int ERR_W  = DEF_DATA_W + 1;
  localparam int DERR_W = DEF_DATA_W + 2;
  localparam int PROD_W = DEF_GAIN_W + DEF_DATA_W + 3;
  localparam int SUM_W  = DEF_ACC_W + 2;

  // Clip a signed value to a signed range of the given width.
  // The symmetric form excludes the most negative code.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int width,
                                                     input logic symmetric);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = symmetric ? -max_v : -max_v - 64'sd1;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed saturator IN_W -> OUT_W with clip flags; SYM selects a symmetric range.
module pid_sat
  import pid_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int OUT_W = 8,
  parameter bit SYM   = 1'b0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    hi,
  output logic                    lo
);

  logic signed [63:0] wide;
  logic signed [63:0] clip;

  always_comb begin
    wide = 64'(din);
    clip = sat_signed(wide, OUT_W, SYM);
    dout = clip[OUT_W-1:0];
    hi   = (clip != wide) && !wide[63];
    lo   = (clip != wide) && wide[63];
  end

endmodule

// File: rtl/pid_ctrl_pipe.sv
// Three-stage fixed-point PID controller: error/derivative, gain products + integrator, sum/scale/saturate.
module pid_ctrl_pipe
  import pid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] feedback,
  input  logic        [GAIN_W-1:0] kp,
  input  logic        [GAIN_W-1:0] ki,
  input  logic        [GAIN_W-1:0] kd,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] control,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int ERR_BITS  = DATA_W + 1;
  localparam int DERR_BITS = DATA_W + 2;
  localparam int PROD_BITS = GAIN_W + DATA_W + 3;
  localparam int SUM_BITS  = ACC_W + 2;

  function automatic logic signed [SUM_BITS-1:0] shr_floor(input logic signed [SUM_BITS-1:0] v);
    return v >>> FRAC_W;
  endfunction

  logic signed [ERR_BITS-1:0]  err_c, prev_err, err_p0;
  logic signed [DERR_BITS-1:0] derr_c, derr_p0;
  logic        [GAIN_W-1:0]    kp_p0, ki_p0, kd_p0;
  logic                        first, vld_p0, vld_p1;
  logic signed [PROD_BITS-1:0] p_c, i_c, d_c, p_p1, d_p1;
  logic signed [ACC_W-1:0]     integ, integ_sat, integ_nxt;
  logic signed [ACC_W:0]       integ_sum;
  logic                        integ_hi, integ_lo, hold;
  logic signed [SUM_BITS-1:0]  sum_c, scaled_c;
  logic signed [DATA_W-1:0]    ctl_c;
  logic                        ctl_hi, ctl_lo;

  // Stage 0: error and first difference
  assign err_c  = ERR_BITS'(setpoint) - ERR_BITS'(feedback);
  assign derr_c = DERR_BITS'(err_c) - DERR_BITS'(prev_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      first    <= 1'b1;
      prev_err <= '0;
    end else if (clear) begin
      vld_p0   <= 1'b0;
      first    <= 1'b1;
      prev_err <= '0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        prev_err <= err_c;
        first    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      err_p0  <= err_c;
      derr_p0 <= first ? '0 : derr_c;
      kp_p0   <= kp;
      ki_p0   <= ki;
      kd_p0   <= kd;
    end
  end

  // Stage 1: gain products and clamped integrator
  assign p_c = PROD_BITS'($signed({1'b0, kp_p0})) * PROD_BITS'(err_p0);
  assign i_c = PROD_BITS'($signed({1'b0, ki_p0})) * PROD_BITS'(err_p0);
  assign d_c = PROD_BITS'($signed({1'b0, kd_p0})) * PROD_BITS'(derr_p0);

  assign integ_sum = (ACC_W + 1)'(integ) + (ACC_W + 1)'(i_c);
  assign integ_nxt = (integ_hi || integ_lo) ? integ_sat : integ_sum[ACC_W-1:0];
  // Freeze the integrator while the last output is pinned and the error would push it further.
  assign hold = (sat_hi && (err_p0 > 0)) || (sat_lo && (err_p0 < 0));

  pid_sat #(.IN_W(ACC_W + 1), .OUT_W(ACC_W), .SYM(1'b1)) u_integ_sat (
    .din (integ_sum),
    .dout(integ_sat),
    .hi  (integ_hi),
    .lo  (integ_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      integ  <= '0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
      integ  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0 && !hold) integ <= integ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      p_p1 <= p_c;
      d_p1 <= d_c;
    end
  end

  // Stage 2: sum, floor scale, output saturation
  assign sum_c    = SUM_BITS'(p_p1) + SUM_BITS'(integ) + SUM_BITS'(d_p1);
  assign scaled_c = shr_floor(sum_c);

  pid_sat #(.IN_W(SUM_BITS), .OUT_W(DATA_W), .SYM(1'b0)) u_out_sat (
    .din (scaled_c),
    .dout(ctl_c),
    .hi  (ctl_hi),
    .lo  (ctl_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      control   <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        control <= ctl_c;
        sat_hi  <= ctl_hi;
        sat_lo  <= ctl_lo;
      end
    end
  end

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Directed-vector bench for pid_ctrl_pipe at the default 8/8/4/24 configuration.
module tb_pid_ctrl_pipe;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] setpoint = '0;
  logic signed [7:0] feedback = '0;
  logic        [7:0] kp = '0, ki = '0, kd = '0;
  logic              out_valid;
  logic signed [7:0] control;
  logic              sat_hi, sat_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_ctrl_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .setpoint (setpoint),
    .feedback (feedback),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .out_valid(out_valid),
    .control  (control),
    .sat_hi   (sat_hi),
    .sat_lo   (sat_lo)
  );

  typedef struct {
    logic       clr;
    logic [7:0] kp, ki, kd;
    int         sp, fb;
    int         ctl;
    logic       hi, lo;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic clr, int gp, int gi, int gd, int sp, int fb,
                              int ctl, logic hi, logic lo);
    vec_t v;
    v.clr = clr; v.kp = 8'(gp); v.ki = 8'(gi); v.kd = 8'(gd);
    v.sp = sp; v.fb = fb; v.ctl = ctl; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Presents one sample and waits (bounded) for its result; returns cycles to out_valid.
  task automatic run_sample(input logic [7:0] gp, gi, gd, input int sp, fb,
                            output int lat, output int ctl, output logic hi, lo);
    kp = gp; ki = gi; kd = gd;
    setpoint = 8'(sp); feedback = 8'(fb);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    ctl = int'(control);
    hi = sat_hi;
    lo = sat_lo;
  endtask

  task automatic burst3();
    kp = 8'd16; ki = 8'd16; kd = 8'd16; feedback = '0;
    for (int i = 0; i < 3; i++) begin
      setpoint = 8'(50 + 10 * i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic quiet_window(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int   lat, ctl;
    logic hi, lo;

    vecs[0]  = mk(1, 16, 0, 0,   50,   20,   30, 0, 0);
    vecs[1]  = mk(1,  8, 0, 0,    0,    3,   -2, 0, 0);
    vecs[2]  = mk(1, 32, 0, 0,  127, -128,  127, 1, 0);
    vecs[3]  = mk(0, 32, 0, 0, -128,  127, -128, 0, 1);
    vecs[4]  = mk(1, 0, 16, 0,   10,    0,   10, 0, 0);
    vecs[5]  = mk(0, 0, 16, 0,   10,    0,   20, 0, 0);
    vecs[6]  = mk(0, 0, 16, 0,   10,    0,   30, 0, 0);
    vecs[7]  = mk(0, 0, 16, 0,   10,    0,   40, 0, 0);
    vecs[8]  = mk(0, 0, 16, 0,   10,    0,   50, 0, 0);
    vecs[9]  = mk(1, 0, 16, 0,   10,    0,   10, 0, 0);
    vecs[10] = mk(1, 0, 0, 16,   10,    0,    0, 0, 0);
    vecs[11] = mk(0, 0, 0, 16,   30,    0,   20, 0, 0);
    vecs[12] = mk(1, 0, 16, 0,  100,    0,  100, 0, 0);
    for (int i = 13; i < 22; i++) vecs[i] = mk(0, 0, 16, 0, 100, 0, 127, 1, 0);
    vecs[22] = mk(0, 0, 16, 0, -100,    0,  100, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_control", int'(control), 0);
    chk("reset_sat_hi", int'(sat_hi), 0);
    chk("reset_sat_lo", int'(sat_lo), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].clr) pulse_clear();
      run_sample(vecs[i].kp, vecs[i].ki, vecs[i].kd, vecs[i].sp, vecs[i].fb, lat, ctl, hi, lo);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_control", i), ctl, vecs[i].ctl);
      chk($sformatf("vec%0d_sat_hi", i), int'(hi), int'(vecs[i].hi));
      chk($sformatf("vec%0d_sat_lo", i), int'(lo), int'(vecs[i].lo));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), int'(out_valid), 0);
    end

    // Async reset with the pipeline full.
    burst3();
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", int'(out_valid), 0);
    chk("rst_async_control", int'(control), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet_window("rst_no_out_valid");
    chk("rst_control_zero", int'(control), 0);
    run_sample(8'd16, 8'd0, 8'd16, 50, 20, lat, ctl, hi, lo);
    chk("rst_fresh_latency", lat, 3);
    chk("rst_fresh_control", ctl, 30);

    // Synchronous clear with the pipeline full; only the oldest sample escapes.
    pulse_clear();
    burst3();
    pulse_clear();
    chk("clr_out_valid", int'(out_valid), 0);
    quiet_window("clr_no_out_valid");
    chk("clr_control_held", int'(control), 100);
    chk("clr_sat_hi", int'(sat_hi), 0);
    run_sample(8'd16, 8'd0, 8'd16, 50, 20, lat, ctl, hi, lo);
    chk("clr_fresh_latency", lat, 3);
    chk("clr_fresh_control", ctl, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
